// File: rtl/ex_pkg.sv
// ex_pkg: ALUOp encodings, R-type Funct codes and the ALU operation enum
// shared by the execute stage and its multiplier.
`default_nettype none

package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_MFHI, OP_MFLO, OP_ZERO
    } alu_op_e;

    // The reserved ALUOp encoding falls through to add.
    function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        op = OP_ADD;
        case (aluop)
            ALUOP_SUB: op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_NOR:  op = OP_NOR;
                    FN_SLT:  op = OP_SLT;
                    FN_MFHI: op = OP_MFHI;
                    FN_MFLO: op = OP_MFLO;
                    default: op = OP_ZERO;
                endcase
            end
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_mul_iter.sv
// mul_iter: 32-cycle shift-add multiplier with HI/LO result registers.
// Signed operands are multiplied as magnitudes; the sign fix-up lands with the final write.
`default_nettype none

module mul_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic        r_busy;
    logic        r_done;
    logic        r_neg;
    logic [4:0]  r_cnt;
    logic [31:0] r_mcand;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_sum;
    logic [63:0] w_step;
    logic [63:0] w_final;

    always_comb begin
        w_mag_a = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
        w_mag_b = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;
        // Upper half accumulates, lower half holds the shifting multiplier bits.
        w_sum   = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
        w_step  = {w_sum, r_prod[31:1]};
        w_final = r_neg ? (~w_step + 64'd1) : w_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_cnt   <= 5'd0;
            r_mcand <= 32'd0;
            r_prod  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_hi   <= w_final[63:32];
                    r_lo   <= w_final[31:0];
                end
            end else if (i_start) begin
                r_busy  <= 1'b1;
                r_cnt   <= 5'd0;
                r_mcand <= w_mag_a;
                r_prod  <= {32'd0, w_mag_b};
                r_neg   <= i_signed & (i_a[31] ^ i_b[31]);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ex_stage: ALU, branch target and EX/MEM latch. Define EX_MULDIV_EN to add
// the iterative multiplier, HI/LO, MFHI/MFLO and the front-end Stall.
`default_nettype none

module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] SignImm,
    input  logic [31:0] PCPlus4,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUOp,
    input  logic [5:0]  Funct,
    input  logic [1:0]  WBControl,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        Branch,
    input  logic        Flush,
    output logic        Stall,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    output logic [31:0] BranchTarget,
    output logic [4:0]  WriteReg,
    output logic [1:0]  WBControl_out,
    output logic        MemWrite_out,
    output logic        MemRead_out,
    output logic        Branch_out,
    output logic        Zero
);

    alu_op_e     w_op;
    logic [31:0] w_b;
    logic [31:0] w_result;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_stall;
    logic        w_bubble;

`ifdef EX_MULDIV_EN
    logic w_mul_busy;
    logic w_mul_done;
    logic w_is_mul;
    logic w_uses_mul;
    logic w_start;
    logic w_unused_done;

    assign w_is_mul   = (ALUOp == ALUOP_RTYPE) && ((Funct == FN_MULT) || (Funct == FN_MULTU));
    assign w_uses_mul = w_is_mul || ((ALUOp == ALUOP_RTYPE) && ((Funct == FN_MFHI) || (Funct == FN_MFLO)));
    // A flushed instruction never stalls and never starts a multiply.
    assign w_stall    = w_mul_busy & w_uses_mul & ~Flush;
    assign w_start    = w_is_mul & ~w_mul_busy & ~Flush;
    assign w_unused_done = w_mul_done;

    mul_iter u_mul_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_signed (Funct == FN_MULT),
        .i_a      (ReadData1),
        .i_b      (ReadData2),
        .o_busy   (w_mul_busy),
        .o_done   (w_mul_done),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );
`else
    assign w_stall = 1'b0;
    assign w_hi    = 32'd0;
    assign w_lo    = 32'd0;
`endif

    always_comb begin
        w_b  = ALUSrc ? SignImm : ReadData2;
        w_op = alu_decode(ALUOp, Funct);
        case (w_op)
            OP_ADD:  w_result = ReadData1 + w_b;
            OP_SUB:  w_result = ReadData1 - w_b;
            OP_AND:  w_result = ReadData1 & w_b;
            OP_OR:   w_result = ReadData1 | w_b;
            OP_NOR:  w_result = ~(ReadData1 | w_b);
            OP_SLT:  w_result = {31'd0, ($signed(ReadData1) < $signed(w_b))};
            OP_MFHI: w_result = w_hi;
            OP_MFLO: w_result = w_lo;
            default: w_result = 32'd0;
        endcase
    end

    assign w_bubble = Flush | w_stall;
    assign Stall    = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult     <= 32'd0;
            WriteData     <= 32'd0;
            BranchTarget  <= 32'd0;
            WriteReg      <= 5'd0;
            WBControl_out <= 2'b00;
            MemWrite_out  <= 1'b0;
            MemRead_out   <= 1'b0;
            Branch_out    <= 1'b0;
            Zero          <= 1'b0;
        end else begin
            ALUResult     <= w_result;
            Zero          <= (w_result == 32'd0);
            WriteData     <= ReadData2;
            BranchTarget  <= PCPlus4 + {SignImm[29:0], 2'b00};
            WriteReg      <= RegDst ? Rd : Rt;
            WBControl_out <= w_bubble ? 2'b00 : WBControl;
            MemWrite_out  <= MemWrite & ~w_bubble;
            MemRead_out   <= MemRead  & ~w_bubble;
            Branch_out    <= Branch   & ~w_bubble;
        end
    end

endmodule

`default_nettype wire
